// File: rtl/axi_read_arbiter.sv
// ----------------------------------------------------------------------------
// axi_read_arbiter
//
// Arbitrates two AXI read-address requesters (instruction fetch "I" and data
// load "D") onto a single shared memory read port. The shared memory returns
// single-beat responses in order. An owner FIFO records which requester each
// accepted read belongs to, so each returning R beat can be routed back to
// its requester.
//
// Ports:
//   clk_i, rst_ni            core clock, asynchronous active-low reset
//   i_arvalid_i/i_arready_o  instruction AR handshake, payload i_ar_i
//   i_rvalid_o/i_rready_i    instruction R handshake, data i_rdata_o
//   d_arvalid_i/d_arready_o  data AR handshake, payload d_ar_i
//   d_rvalid_o/d_rready_i    data R handshake, data d_rdata_o
//   m_arvalid_o/m_arready_i  shared memory AR handshake, payload m_ar_o
//   m_rvalid_i/m_rready_o    shared memory R handshake, data m_rdata_i
//   outstanding_o            reads accepted but not yet returned
//   err_unexpected_r_o       sticky: R beat seen with nothing outstanding
//
// AR payload packing: {araddr[31:0], arprot[2:0], arcache[3:0], arsize[1:0]}
// ----------------------------------------------------------------------------
module axi_read_arbiter #(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,

    input  logic                               i_arvalid_i,
    output logic                               i_arready_o,
    input  logic [40:0]                        i_ar_i,
    output logic                               i_rvalid_o,
    input  logic                               i_rready_i,
    output logic [31:0]                        i_rdata_o,

    input  logic                               d_arvalid_i,
    output logic                               d_arready_o,
    input  logic [40:0]                        d_ar_i,
    output logic                               d_rvalid_o,
    input  logic                               d_rready_i,
    output logic [31:0]                        d_rdata_o,

    output logic                               m_arvalid_o,
    input  logic                               m_arready_i,
    output logic [40:0]                        m_ar_o,
    input  logic                               m_rvalid_i,
    output logic                               m_rready_o,
    input  logic [31:0]                        m_rdata_i,

    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_o,
    output logic                               err_unexpected_r_o
);

    localparam int PW = $clog2(MAX_OUTSTANDING);
    localparam int CW = PW + 1;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_e;

    state_e          state_q;
    logic [40:0]     payload_q;
    logic            last_q;

    logic            owner_q [MAX_OUTSTANDING];
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;
    logic            err_q;

    logic            fifo_full;
    logic            fifo_empty;
    logic            head;
    logic            grant_i;
    logic            grant_d;
    logic            push;
    logic            pop;

    assign fifo_full  = (count_q == CW'(MAX_OUTSTANDING));
    assign fifo_empty = (count_q == '0);
    assign head       = owner_q[rd_ptr_q];

    // Grant only in IDLE with FIFO space. On a tie the requester that did not
    // win last time gets the slot. A pop in the same cycle does not free space
    // for this cycle's grant: fullness is judged on the registered count.
    // Gating with rst_ni keeps both arready outputs low while reset is held.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (rst_ni && (state_q == IDLE) && !fifo_full) begin
            if (i_arvalid_i && (!d_arvalid_i || (last_q == OWN_D))) begin
                grant_i = 1'b1;
            end else if (d_arvalid_i) begin
                grant_d = 1'b1;
            end
        end
    end

    assign i_arready_o = grant_i;
    assign d_arready_o = grant_d;
    assign push        = grant_i | grant_d;

    // R path is purely combinational: the FIFO head selects which upstream
    // port sees m_rvalid_i and which rready goes back to memory.
    always_comb begin
        i_rvalid_o = 1'b0;
        d_rvalid_o = 1'b0;
        m_rready_o = 1'b0;
        if (!fifo_empty) begin
            if (head == OWN_I) begin
                i_rvalid_o = m_rvalid_i;
                m_rready_o = i_rready_i;
            end else begin
                d_rvalid_o = m_rvalid_i;
                m_rready_o = d_rready_i;
            end
        end
    end

    assign pop       = m_rvalid_i & m_rready_o;
    assign count_d   = count_q + CW'(push) - CW'(pop);
    assign i_rdata_o = m_rdata_i;
    assign d_rdata_o = m_rdata_i;

    // AR FSM: capture the winning payload and owner in IDLE, present it to
    // memory in ISSUE until accepted. m_arvalid_o/m_ar_o come straight from
    // registers, so the held request is stable under backpressure.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            payload_q <= '0;
            last_q    <= OWN_D;
        end else begin
            case (state_q)
                IDLE: begin
                    if (push) begin
                        payload_q <= grant_i ? i_ar_i : d_ar_i;
                        last_q    <= grant_d ? OWN_D : OWN_I;
                        state_q   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (m_arready_i) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign m_arvalid_o = (state_q == ISSUE);
    assign m_ar_o      = payload_q;

    // Owner FIFO: pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int k = 0; k < MAX_OUTSTANDING; k++) begin
                owner_q[k] <= OWN_I;
            end
        end else begin
            if (push) begin
                owner_q[wr_ptr_q] <= grant_d ? OWN_D : OWN_I;
                wr_ptr_q          <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_d;
        end
    end

    assign outstanding_o = count_q;

    // Sticky error: any R beat while nothing is outstanding.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else if (m_rvalid_i && fifo_empty) begin
            err_q <= 1'b1;
        end
    end

    assign err_unexpected_r_o = err_q;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// ----------------------------------------------------------------------------
// tb_axi_read_arbiter
//
// Directed testbench for axi_read_arbiter (MAX_OUTSTANDING = 4). Inputs are
// driven 1 time unit after the rising edge; outputs are sampled on the
// falling edge. Each scenario task carries its own expected values.
// ----------------------------------------------------------------------------
module tb_axi_read_arbiter;

    logic        clk_i;
    logic        rst_ni;
    logic        i_arvalid_i, i_arready_o, i_rvalid_o, i_rready_i;
    logic [40:0] i_ar_i;
    logic [31:0] i_rdata_o;
    logic        d_arvalid_i, d_arready_o, d_rvalid_o, d_rready_i;
    logic [40:0] d_ar_i;
    logic [31:0] d_rdata_o;
    logic        m_arvalid_o, m_arready_i, m_rvalid_i, m_rready_o;
    logic [40:0] m_ar_o;
    logic [31:0] m_rdata_i;
    logic [2:0]  outstanding_o;
    logic        err_unexpected_r_o;

    int passed = 0;
    int total  = 0;

    localparam logic [40:0] PL_I0 = {32'h0000_1000, 3'b100, 4'b0010, 2'b10};
    localparam logic [40:0] PL_I1 = {32'h0000_2004, 3'b101, 4'b0011, 2'b10};
    localparam logic [40:0] PL_D0 = {32'h8000_0040, 3'b000, 4'b1111, 2'b01};
    localparam logic [40:0] PL_D1 = {32'h8000_0088, 3'b010, 4'b0110, 2'b00};

    axi_read_arbiter #(.MAX_OUTSTANDING(4)) dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .i_arvalid_i        (i_arvalid_i),
        .i_arready_o        (i_arready_o),
        .i_ar_i             (i_ar_i),
        .i_rvalid_o         (i_rvalid_o),
        .i_rready_i         (i_rready_i),
        .i_rdata_o          (i_rdata_o),
        .d_arvalid_i        (d_arvalid_i),
        .d_arready_o        (d_arready_o),
        .d_ar_i             (d_ar_i),
        .d_rvalid_o         (d_rvalid_o),
        .d_rready_i         (d_rready_i),
        .d_rdata_o          (d_rdata_o),
        .m_arvalid_o        (m_arvalid_o),
        .m_arready_i        (m_arready_i),
        .m_ar_o             (m_ar_o),
        .m_rvalid_i         (m_rvalid_i),
        .m_rready_o         (m_rready_o),
        .m_rdata_i          (m_rdata_i),
        .outstanding_o      (outstanding_o),
        .err_unexpected_r_o (err_unexpected_r_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation exceeded time limit");
        $fatal(1, "[TB] timeout");
    end

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drain(input int n);
        m_rvalid_i = 1'b1; i_rready_i = 1'b1; d_rready_i = 1'b1;
        for (int k = 0; k < n; k++) begin
            m_rdata_i = 32'h5A00_0000 + 32'(k);
            next_cycle();
        end
        m_rvalid_i = 1'b0; i_rready_i = 1'b0; d_rready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        i_arvalid_i = 1'b1; d_arvalid_i = 1'b1; i_ar_i = PL_I0; d_ar_i = PL_D0;
        m_arready_i = 1'b1; m_rvalid_i = 1'b1; m_rdata_i = 32'h0;
        i_rready_i = 1'b1; d_rready_i = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        if (i_arready_o !== 1'b0) $display("[TB] FAIL rst_i_arready: got %0h expected 0", i_arready_o); else passed++; total++;
        if (d_arready_o !== 1'b0) $display("[TB] FAIL rst_d_arready: got %0h expected 0", d_arready_o); else passed++; total++;
        if (m_arvalid_o !== 1'b0) $display("[TB] FAIL rst_m_arvalid: got %0h expected 0", m_arvalid_o); else passed++; total++;
        if (m_rready_o !== 1'b0) $display("[TB] FAIL rst_m_rready: got %0h expected 0", m_rready_o); else passed++; total++;
        if ({i_rvalid_o, d_rvalid_o} !== 2'b00) $display("[TB] FAIL rst_rvalid: got %0h expected 0", {i_rvalid_o, d_rvalid_o}); else passed++; total++;
        if (outstanding_o !== 3'd0) $display("[TB] FAIL rst_outstanding: got %0d expected 0", outstanding_o); else passed++; total++;
        if (err_unexpected_r_o !== 1'b0) $display("[TB] FAIL rst_err: got %0h expected 0", err_unexpected_r_o); else passed++; total++;
        if (m_ar_o !== 41'h0) $display("[TB] FAIL rst_m_ar: got %0h expected 0", m_ar_o); else passed++; total++;
        i_arvalid_i = 1'b0; d_arvalid_i = 1'b0; m_arready_i = 1'b0; m_rvalid_i = 1'b0;
        i_rready_i = 1'b0; d_rready_i = 1'b0;
        rst_ni = 1'b1;
        next_cycle();
    endtask

    task automatic test_tie();
        i_arvalid_i = 1'b1; i_ar_i = PL_I0; d_arvalid_i = 1'b1; d_ar_i = PL_D0; m_arready_i = 1'b0;
        @(negedge clk_i);
        if (i_arready_o !== 1'b1) $display("[TB] FAIL tie_i_arready: got %0h expected 1", i_arready_o); else passed++; total++;
        if (d_arready_o !== 1'b0) $display("[TB] FAIL tie_d_arready: got %0h expected 0", d_arready_o); else passed++; total++;
        if (m_arvalid_o !== 1'b0) $display("[TB] FAIL tie_idle_m_arvalid: got %0h expected 0", m_arvalid_o); else passed++; total++;
        next_cycle();
        i_arvalid_i = 1'b0; m_arready_i = 1'b1;
        @(negedge clk_i);
        if (m_arvalid_o !== 1'b1) $display("[TB] FAIL tie_m_arvalid: got %0h expected 1", m_arvalid_o); else passed++; total++;
        if (m_ar_o !== PL_I0) $display("[TB] FAIL tie_m_ar_i: got %0h expected %0h", m_ar_o, PL_I0); else passed++; total++;
        if (d_arready_o !== 1'b0) $display("[TB] FAIL tie_issue_d_arready: got %0h expected 0", d_arready_o); else passed++; total++;
        if (outstanding_o !== 3'd1) $display("[TB] FAIL tie_outstanding1: got %0d expected 1", outstanding_o); else passed++; total++;
        next_cycle();
        @(negedge clk_i);
        if (d_arready_o !== 1'b1) $display("[TB] FAIL tie_d_after: got %0h expected 1", d_arready_o); else passed++; total++;
        if (m_arvalid_o !== 1'b0) $display("[TB] FAIL tie_idle2_m_arvalid: got %0h expected 0", m_arvalid_o); else passed++; total++;
        next_cycle();
        d_arvalid_i = 1'b0;
        @(negedge clk_i);
        if (m_ar_o !== PL_D0) $display("[TB] FAIL tie_m_ar_d: got %0h expected %0h", m_ar_o, PL_D0); else passed++; total++;
        next_cycle();
        m_arready_i = 1'b0;
        m_rvalid_i = 1'b1; m_rdata_i = 32'h11; i_rready_i = 1'b1; d_rready_i = 1'b1;
        @(negedge clk_i);
        if (outstanding_o !== 3'd2) $display("[TB] FAIL tie_outstanding2: got %0d expected 2", outstanding_o); else passed++; total++;
        if ({i_rvalid_o, d_rvalid_o} !== 2'b10) $display("[TB] FAIL tie_r1_route: got %0b expected 10", {i_rvalid_o, d_rvalid_o}); else passed++; total++;
        if (i_rdata_o !== 32'h11) $display("[TB] FAIL tie_r1_data: got %0h expected 11", i_rdata_o); else passed++; total++;
        next_cycle();
        m_rdata_i = 32'h22;
        @(negedge clk_i);
        if ({i_rvalid_o, d_rvalid_o} !== 2'b01) $display("[TB] FAIL tie_r2_route: got %0b expected 01", {i_rvalid_o, d_rvalid_o}); else passed++; total++;
        if (d_rdata_o !== 32'h22) $display("[TB] FAIL tie_r2_data: got %0h expected 22", d_rdata_o); else passed++; total++;
        next_cycle();
        m_rvalid_i = 1'b0; i_rready_i = 1'b0; d_rready_i = 1'b0;
        @(negedge clk_i);
        if (outstanding_o !== 3'd0) $display("[TB] FAIL tie_drained: got %0d expected 0", outstanding_o); else passed++; total++;
        next_cycle();
    endtask

    task automatic test_backpressure();
        i_arvalid_i = 1'b1; i_ar_i = PL_I1; m_arready_i = 1'b0;
        @(negedge clk_i);
        if (i_arready_o !== 1'b1) $display("[TB] FAIL bp_accept: got %0h expected 1", i_arready_o); else passed++; total++;
        next_cycle();
        d_arvalid_i = 1'b1; d_ar_i = PL_D1; i_ar_i = PL_I0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_i);
            if (m_ar_o !== PL_I1) $display("[TB] FAIL bp_hold_%0d: got %0h expected %0h", k, m_ar_o, PL_I1); else passed++; total++;
            if ({m_arvalid_o, i_arready_o, d_arready_o} !== 3'b100) $display("[TB] FAIL bp_ctrl_%0d: got %0b expected 100", k, {m_arvalid_o, i_arready_o, d_arready_o}); else passed++; total++;
            next_cycle();
        end
        m_arready_i = 1'b1;
        next_cycle();
        m_arready_i = 1'b0;
        @(negedge clk_i);
        if ({i_arready_o, d_arready_o} !== 2'b01) $display("[TB] FAIL bp_rr_d_wins: got %0b expected 01", {i_arready_o, d_arready_o}); else passed++; total++;
        next_cycle();
        i_arvalid_i = 1'b0; d_arvalid_i = 1'b0; m_arready_i = 1'b1;
        @(negedge clk_i);
        if (m_ar_o !== PL_D1) $display("[TB] FAIL bp_m_ar_d: got %0h expected %0h", m_ar_o, PL_D1); else passed++; total++;
        next_cycle();
        m_arready_i = 1'b0;
        drain(2);
        @(negedge clk_i);
        if (outstanding_o !== 3'd0) $display("[TB] FAIL bp_drained: got %0d expected 0", outstanding_o); else passed++; total++;
        next_cycle();
    endtask

    task automatic test_full();
        i_arvalid_i = 1'b1; m_arready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            i_ar_i = {32'h2000_0000 + 32'(k * 4), 9'h0};
            @(negedge clk_i);
            if (i_arready_o !== 1'b1) $display("[TB] FAIL full_accept_%0d: got %0h expected 1", k, i_arready_o); else passed++; total++;
            next_cycle();
            @(negedge clk_i);
            if (outstanding_o !== 3'(k + 1)) $display("[TB] FAIL full_count_%0d: got %0d expected %0d", k, outstanding_o, k + 1); else passed++; total++;
            next_cycle();
        end
        @(negedge clk_i);
        if (outstanding_o !== 3'd4) $display("[TB] FAIL full_outstanding: got %0d expected 4", outstanding_o); else passed++; total++;
        if (i_arready_o !== 1'b0) $display("[TB] FAIL full_blocked: got %0h expected 0", i_arready_o); else passed++; total++;
        next_cycle();
        m_rvalid_i = 1'b1; i_rready_i = 1'b1;
        @(negedge clk_i);
        if (m_rready_o !== 1'b1) $display("[TB] FAIL full_pop_rready: got %0h expected 1", m_rready_o); else passed++; total++;
        if (i_arready_o !== 1'b0) $display("[TB] FAIL full_pop_same_cycle: got %0h expected 0", i_arready_o); else passed++; total++;
        next_cycle();
        m_rvalid_i = 1'b0; i_rready_i = 1'b0;
        @(negedge clk_i);
        if (outstanding_o !== 3'd3) $display("[TB] FAIL full_after_pop: got %0d expected 3", outstanding_o); else passed++; total++;
        if (i_arready_o !== 1'b1) $display("[TB] FAIL full_reaccept: got %0h expected 1", i_arready_o); else passed++; total++;
        next_cycle();
        i_arvalid_i = 1'b0;
        next_cycle();
        m_arready_i = 1'b0;
        drain(4);
        @(negedge clk_i);
        if (outstanding_o !== 3'd0) $display("[TB] FAIL full_drained: got %0d expected 0", outstanding_o); else passed++; total++;
        next_cycle();
    endtask

    task automatic test_order();
        m_arready_i = 1'b1;
        i_arvalid_i = 1'b1; i_ar_i = PL_I0;
        @(negedge clk_i);
        if (i_arready_o !== 1'b1) $display("[TB] FAIL ord_acc_i0: got %0h expected 1", i_arready_o); else passed++; total++;
        next_cycle();
        i_arvalid_i = 1'b0;
        next_cycle();
        d_arvalid_i = 1'b1; d_ar_i = PL_D0;
        @(negedge clk_i);
        if (d_arready_o !== 1'b1) $display("[TB] FAIL ord_acc_d: got %0h expected 1", d_arready_o); else passed++; total++;
        next_cycle();
        d_arvalid_i = 1'b0;
        next_cycle();
        i_arvalid_i = 1'b1; i_ar_i = PL_I1;
        @(negedge clk_i);
        if (i_arready_o !== 1'b1) $display("[TB] FAIL ord_acc_i1: got %0h expected 1", i_arready_o); else passed++; total++;
        next_cycle();
        i_arvalid_i = 1'b0;
        next_cycle();
        m_arready_i = 1'b0;
        m_rvalid_i = 1'b1; m_rdata_i = 32'hA; i_rready_i = 1'b1; d_rready_i = 1'b0;
        @(negedge clk_i);
        if (outstanding_o !== 3'd3) $display("[TB] FAIL ord_outstanding: got %0d expected 3", outstanding_o); else passed++; total++;
        if ({i_rvalid_o, d_rvalid_o, m_rready_o} !== 3'b101) $display("[TB] FAIL ord_beat_a: got %0b expected 101", {i_rvalid_o, d_rvalid_o, m_rready_o}); else passed++; total++;
        if (i_rdata_o !== 32'hA) $display("[TB] FAIL ord_data_a: got %0h expected a", i_rdata_o); else passed++; total++;
        next_cycle();
        m_rdata_i = 32'hB;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk_i);
            if ({i_rvalid_o, d_rvalid_o, m_rready_o} !== 3'b010) $display("[TB] FAIL ord_stall_%0d: got %0b expected 010", k, {i_rvalid_o, d_rvalid_o, m_rready_o}); else passed++; total++;
            if (outstanding_o !== 3'd2) $display("[TB] FAIL ord_stall_cnt_%0d: got %0d expected 2", k, outstanding_o); else passed++; total++;
            next_cycle();
        end
        d_rready_i = 1'b1;
        @(negedge clk_i);
        if (m_rready_o !== 1'b1) $display("[TB] FAIL ord_beat_b_rready: got %0h expected 1", m_rready_o); else passed++; total++;
        if (d_rdata_o !== 32'hB) $display("[TB] FAIL ord_data_b: got %0h expected b", d_rdata_o); else passed++; total++;
        next_cycle();
        m_rdata_i = 32'hC; d_rready_i = 1'b0;
        @(negedge clk_i);
        if ({i_rvalid_o, d_rvalid_o, m_rready_o} !== 3'b101) $display("[TB] FAIL ord_beat_c: got %0b expected 101", {i_rvalid_o, d_rvalid_o, m_rready_o}); else passed++; total++;
        if (i_rdata_o !== 32'hC) $display("[TB] FAIL ord_data_c: got %0h expected c", i_rdata_o); else passed++; total++;
        next_cycle();
        m_rvalid_i = 1'b0; i_rready_i = 1'b0;
        @(negedge clk_i);
        if (outstanding_o !== 3'd0) $display("[TB] FAIL ord_drained: got %0d expected 0", outstanding_o); else passed++; total++;
        next_cycle();
    endtask

    task automatic test_spurious();
        m_rvalid_i = 1'b1; m_rdata_i = 32'hDEAD; i_rready_i = 1'b1; d_rready_i = 1'b1;
        @(negedge clk_i);
        if ({m_rready_o, i_rvalid_o, d_rvalid_o} !== 3'b000) $display("[TB] FAIL spur_blocked: got %0b expected 000", {m_rready_o, i_rvalid_o, d_rvalid_o}); else passed++; total++;
        if (err_unexpected_r_o !== 1'b0) $display("[TB] FAIL spur_err_same_cycle: got %0h expected 0", err_unexpected_r_o); else passed++; total++;
        next_cycle();
        m_rvalid_i = 1'b0; i_rready_i = 1'b0; d_rready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            if (err_unexpected_r_o !== 1'b1) $display("[TB] FAIL spur_err_sticky_%0d: got %0h expected 1", k, err_unexpected_r_o); else passed++; total++;
            next_cycle();
        end
    endtask

    task automatic test_reset_mid();
        i_arvalid_i = 1'b1; i_ar_i = PL_I1; m_arready_i = 1'b1;
        next_cycle();
        next_cycle();
        next_cycle();
        next_cycle();
        next_cycle();
        i_arvalid_i = 1'b0; m_arready_i = 1'b0;
        @(negedge clk_i);
        if (outstanding_o !== 3'd3) $display("[TB] FAIL rmid_before: got %0d expected 3", outstanding_o); else passed++; total++;
        if (m_arvalid_o !== 1'b1) $display("[TB] FAIL rmid_held: got %0h expected 1", m_arvalid_o); else passed++; total++;
        #2;
        rst_ni = 1'b0; m_rvalid_i = 1'b1; i_rready_i = 1'b1;
        #1;
        if (outstanding_o !== 3'd0) $display("[TB] FAIL rmid_outstanding: got %0d expected 0", outstanding_o); else passed++; total++;
        if (m_arvalid_o !== 1'b0) $display("[TB] FAIL rmid_m_arvalid: got %0h expected 0", m_arvalid_o); else passed++; total++;
        if ({m_rready_o, i_rvalid_o} !== 2'b00) $display("[TB] FAIL rmid_no_route: got %0b expected 00", {m_rready_o, i_rvalid_o}); else passed++; total++;
        if (err_unexpected_r_o !== 1'b0) $display("[TB] FAIL rmid_err_cleared: got %0h expected 0", err_unexpected_r_o); else passed++; total++;
        if (m_ar_o !== 41'h0) $display("[TB] FAIL rmid_payload: got %0h expected 0", m_ar_o); else passed++; total++;
        @(negedge clk_i);
        m_rvalid_i = 1'b0; i_rready_i = 1'b0;
        rst_ni = 1'b1;
        next_cycle();
        i_arvalid_i = 1'b1; i_ar_i = PL_I0; d_arvalid_i = 1'b1; d_ar_i = PL_D0;
        @(negedge clk_i);
        if ({i_arready_o, d_arready_o} !== 2'b10) $display("[TB] FAIL rmid_regrant: got %0b expected 10", {i_arready_o, d_arready_o}); else passed++; total++;
        next_cycle();
        i_arvalid_i = 1'b0; d_arvalid_i = 1'b0; m_arready_i = 1'b1;
        @(negedge clk_i);
        if (m_ar_o !== PL_I0) $display("[TB] FAIL rmid_payload_after: got %0h expected %0h", m_ar_o, PL_I0); else passed++; total++;
        if (outstanding_o !== 3'd1) $display("[TB] FAIL rmid_count_after: got %0d expected 1", outstanding_o); else passed++; total++;
        next_cycle();
        m_arready_i = 1'b0;
        drain(1);
    endtask

    initial begin
        test_reset();
        test_tie();
        test_backpressure();
        test_full();
        test_order();
        test_spurious();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/axi_read_arbiter.md
AXI_READ_ARBITER -- requirements
Module: axi_read_arbiter

Interface
REQ-001 Parameter: MAX_OUTSTANDING, default 4, sets the maximum number of accepted reads without a returned R beat (power of two, 2..16).
REQ-002 clk_i  input  1  core clock; all state updates on its rising edge.
REQ-003 rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-004 i_arvalid_i  input  1  instruction-fetch read request valid.
REQ-005 i_arready_o  output  1  instruction request accepted this cycle.
REQ-006 i_ar_i  input  41  instruction AR payload, packed {araddr[31:0], arprot[2:0], arcache[3:0], arsize[1:0]}.
REQ-007 i_rvalid_o  output  1  read data valid to fetch.
REQ-008 i_rready_i  input  1  fetch ready for read data.
REQ-009 i_rdata_o  output  32  read data to fetch.
REQ-010 d_arvalid_i  input  1  data-load read request valid.
REQ-011 d_arready_o  output  1  data request accepted this cycle.
REQ-012 d_ar_i  input  41  data AR payload, same packing as i_ar_i.
REQ-013 d_rvalid_o  output  1  read data valid to load unit.
REQ-014 d_rready_i  input  1  load unit ready for read data.
REQ-015 d_rdata_o  output  32  read data to load unit.
REQ-016 m_arvalid_o  output  1  shared memory AR valid.
REQ-017 m_arready_i  input  1  shared memory AR ready.
REQ-018 m_ar_o  output  41  shared AR payload, same packing.
REQ-019 m_rvalid_i  input  1  shared memory R valid; single-beat, in-order responses.
REQ-020 m_rready_o  output  1  shared memory R ready.
REQ-021 m_rdata_i  input  32  shared memory read data.
REQ-022 outstanding_o  output  $clog2(MAX_OUTSTANDING)+1  count of accepted reads not yet returned.
REQ-023 err_unexpected_r_o  output  1  sticky flag for an R beat that arrived with no read outstanding.

Function
REQ-024 The AR FSM SHALL have two states:
- IDLE: no request held.
- ISSUE: one request held in the payload register.
REQ-025 In IDLE with owner FIFO not full, the block SHALL accept exactly one requester: assert its arready combinationally in the same cycle, capture its payload and owner ID, push the owner into the FIFO, and enter ISSUE.
REQ-026 When both arvalid are high in IDLE, the block SHALL grant round-robin: the requester not granted last wins.
REQ-027 When only one arvalid is high in IDLE, the block SHALL grant that requester and record it as last granted.
REQ-028 In IDLE with the FIFO full, both arready outputs SHALL be 0, even if an R pop occurs in the same cycle.
REQ-029 In ISSUE, m_arvalid_o SHALL be 1 and m_ar_o SHALL equal the held payload, stable until m_arvalid_o && m_arready_i; the state then returns to IDLE.
REQ-030 In IDLE, m_arvalid_o SHALL be 0, and both upstream arready outputs SHALL be 0 in ISSUE.
REQ-031 AR throughput SHALL be at most one accept per two cycles.
REQ-032 The owner FIFO SHALL have MAX_OUTSTANDING entries, with pointers wrapping modulo depth.
- A simultaneous push and pop SHALL leave the count unchanged.
- outstanding_o SHALL equal the FIFO occupancy.
REQ-033 R routing, with FIFO non-empty and head = I:
- i_rvalid_o = m_rvalid_i
- m_rready_o = i_rready_i
- d_rvalid_o = 0
The mirror rule SHALL apply for head = D.
REQ-034 The FIFO SHALL pop on m_rvalid_i && m_rready_o, with zero added latency on the R path.
REQ-035 i_rdata_o and d_rdata_o SHALL both equal m_rdata_i at all times.
REQ-036 With the FIFO empty:
- m_rready_o, i_rvalid_o and d_rvalid_o SHALL be 0.
- m_rvalid_i = 1 SHALL set err_unexpected_r_o, which holds until reset.

Reset
REQ-037 While rst_ni = 0, the block SHALL hold:
- state IDLE, FIFO empty, outstanding_o = 0
- last-granted = D, so I wins the first tie
- held payload = 0
- all valid and ready outputs 0, err_unexpected_r_o = 0
REQ-038 Reset asserted mid-transaction SHALL discard the held request and all outstanding owners immediately, with no further R routing.

Verification
REQ-039 Tie after reset: i_arvalid = d_arvalid = 1 in cycle 0 -> i_arready = 1 in cycle 0; m_arvalid = 1 in cycle 1 with I payload; after the AR handshake, d_arready = 1 in the next IDLE cycle.
REQ-040 Backpressure: m_arready held 0 for 5 cycles in ISSUE -> m_ar_o is unchanged on every cycle and no upstream arready is asserted.
REQ-041 Full: MAX_OUTSTANDING = 4, four reads accepted, no R returned -> outstanding_o = 4 and a fifth request sees arready = 0; one R pop -> the request is accepted in the following IDLE cycle.
REQ-042 Ordering: accept order I, D, I, with R data 0xA, 0xB, 0xC -> fetch receives 0xA then 0xC; load unit receives 0xB; a stall on d_rready holds m_rready = 0 while D is at the FIFO head.
REQ-043 Spurious response: m_rvalid = 1 with the FIFO empty -> m_rready = 0 and err_unexpected_r_o = 1 from the next cycle until reset.
REQ-044 Reset with 3 reads outstanding -> outstanding_o = 0 and state IDLE; the next request is granted normally.
